// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiplier/divider: one shift-add/subtract step per cycle,
// fixed 33-cycle latency from the start edge to a one-cycle result-ready strobe.
module multdiv_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam int unsigned W         = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned LAST_STEP = 31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [2*W-1:0]     acc;
    logic [W-1:0]       mag;
    logic               neg;
    logic               is_div;
    logic               div_zero;
    logic               div_ovf;

    logic               start_mult_c;
    logic               start_div_c;
    logic               start_c;
    logic [W-1:0]       a_mag_c;
    logic [W-1:0]       b_mag_c;
    logic [W:0]         mul_sum_c;
    logic [2*W-1:0]     mul_next_c;
    logic [W:0]         div_shift_c;
    logic [W:0]         div_diff_c;
    logic               div_ge_c;
    logic [2*W-1:0]     div_next_c;
    logic [2*W-1:0]     prod_c;
    logic [W-1:0]       quot_c;
    logic [W-1:0]       res_c;
    logic               exc_c;

    // Start decode: multiply has priority when both pulses are present.
    assign start_mult_c = ctrl_MULT;
    assign start_div_c  = ctrl_DIV & ~ctrl_MULT;
    assign start_c      = ctrl_MULT | ctrl_DIV;

    // Magnitudes; the most negative value maps to 2^31 as an unsigned number.
    assign a_mag_c = data_operandA[W-1] ? (~data_operandA + W'(1)) : data_operandA;
    assign b_mag_c = data_operandB[W-1] ? (~data_operandB + W'(1)) : data_operandB;

    // Multiply step: conditional add into the upper half, then shift right with carry.
    assign mul_sum_c  = {1'b0, acc[2*W-1:W]} + {1'b0, mag};
    assign mul_next_c = acc[0] ? {mul_sum_c, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

    // Divide step: upper half is the remainder, lower half shifts dividend out / quotient in.
    assign div_shift_c = {acc[2*W-1:W], acc[W-1]};
    assign div_ge_c    = (div_shift_c >= {1'b0, mag});
    assign div_diff_c  = div_shift_c - {1'b0, mag};
    assign div_next_c  = div_ge_c ? {div_diff_c[W-1:0], acc[W-2:0], 1'b1}
                                  : {div_shift_c[W-1:0], acc[W-2:0], 1'b0};

    // Sign fix-up and exception flags for the finished operation.
    always_comb begin
        prod_c = neg ? (~acc + (2*W)'(1)) : acc;
        quot_c = neg ? (~acc[W-1:0] + W'(1)) : acc[W-1:0];
        res_c  = prod_c[W-1:0];
        exc_c  = (prod_c[2*W-1:W] != {W{prod_c[W-1]}});
        if (is_div) begin
            res_c = div_zero ? '0 : quot_c;
            exc_c = div_zero | div_ovf;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: a start from any state restarts; DONE lasts exactly one cycle.
    always_comb begin
        state_n = state;
        case (state)
            S_MULT, S_DIV: begin
                if (cnt == CNT_W'(LAST_STEP)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = state;
        endcase
        if (start_mult_c) begin
            state_n = S_MULT;
        end else if (start_div_c) begin
            state_n = S_DIV;
        end
    end

    // Datapath and registered outputs; DONE publishes even if a new start arrives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            acc            <= '0;
            mag            <= '0;
            neg            <= 1'b0;
            is_div         <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= (state == S_DONE);
            if (state == S_DONE) begin
                data_result    <= res_c;
                data_exception <= exc_c;
            end
            if (start_c) begin
                cnt      <= '0;
                is_div   <= start_div_c;
                neg      <= data_operandA[W-1] ^ data_operandB[W-1];
                acc      <= start_mult_c ? {{W{1'b0}}, b_mag_c} : {{W{1'b0}}, a_mag_c};
                mag      <= start_mult_c ? a_mag_c : b_mag_c;
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == {1'b1, {(W-1){1'b0}}}) &&
                            (data_operandB == {W{1'b1}});
            end else if (state == S_MULT) begin
                acc <= mul_next_c;
                cnt <= cnt + CNT_W'(1);
            end else if (state == S_DIV) begin
                acc <= div_next_c;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: stimulus pushes expected results with their due
// cycle, a negedge monitor pops and checks every ready strobe.
module tb_multdiv_iter;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   failures;

    multdiv_iter dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count rising edges; a value sampled at a negedge names the edge just passed.
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready strobe must match the oldest pending expectation.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_rdy: got rdy=1 expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("exception", 32'(data_exception), 32'(e.exc));
                check("rdy_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; the next rising edge is E0. Returns at the negedge after E0.
    task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] r, input logic x);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (push) begin
            e.res = r;
            e.exc = x;
            e.due = cyc + 34;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    // Wait (bounded) until every expected result has been seen.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clock);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_rdy", 32'(data_resultRDY), 32'd0);
        check("reset_result", data_result, 32'd0);
        check("reset_exc", 32'(data_exception), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 7 * -3 with explicit strobe-width checks around E33
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0);
        repeat (32) @(negedge clock);
        check("rdy_low_e32", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        check("rdy_high_e33", 32'(data_resultRDY), 32'd1);
        @(negedge clock);
        check("rdy_low_e34", 32'(data_resultRDY), 32'd0);
        drain();

        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 1'b1);
        drain();
        start(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        drain();
        start(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 1'b1);
        drain();

        start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0);
        drain();
        start(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        drain();
        start(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 1'b0);
        drain();
        start(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1);
        drain();
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        drain();

        // Abort: MULT at E0, DIV restart at E10, single result at E43
        start(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0);
        repeat (9) @(negedge clock);
        start(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        drain();

        start(1'b1, 1'b1, 32'd6, 32'd3, 1'b1, 32'd18, 1'b0);
        drain();

        // New start on the same edge as the DONE exit
        start(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0);
        repeat (32) @(negedge clock);
        start(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0);
        drain();

        // Reset mid-operation
        start(1'b1, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0);
        repeat (14) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("midreset_rdy", 32'(data_resultRDY), 32'd0);
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", 32'(data_exception), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("post_reset_result", data_result, 32'd0);
        check("post_reset_exc", 32'(data_exception), 32'd0);
        start(1'b1, 1'b0, 32'd5, 32'd5, 1'b1, 32'd25, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
